// File: rtl/door_sequencer.sv
// door_sequencer: four-state door FSM (closed/opening/open/closing) paced by a tick prescaler.
// Optional macro DOOR_NUDGE_EN: after MAX_REOPEN reopens, close slowly and let only overload reopen.
module door_sequencer #(
   parameter int CNT_W      = 16,
   parameter int TICK_DIV   = 2,
   parameter int OPEN_TIME  = 3,
   parameter int DWELL_TIME = 4,
   parameter int CLOSE_TIME = 3,
   parameter int MAX_REOPEN = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       open_req,
   input  logic       close_req,
   input  logic       weight_limit_exceeded,
   input  logic       obstruction,
   output logic [1:0] door_state,
   output logic       door_closed,
   output logic       door_fully_open,
   output logic       door_busy,
   output logic       door_tick,
   output logic       nudge
);

   typedef enum logic [1:0] {
      ST_CLOSED  = 2'd0,
      ST_OPENING = 2'd1,
      ST_OPEN    = 2'd2,
      ST_CLOSING = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] OPEN_LAST  = CNT_W'(OPEN_TIME - 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_TIME - 1);
   localparam logic [CNT_W-1:0] CLOSE_LAST = CNT_W'(CLOSE_TIME - 1);

   if (TICK_DIV < 1 || OPEN_TIME < 1 || DWELL_TIME < 1 || CLOSE_TIME < 1) begin : g_chk_times
      $error("door_sequencer: TICK_DIV and all phase times must be >= 1");
   end
   if (MAX_REOPEN < 1) begin : g_chk_reopen
      $error("door_sequencer: MAX_REOPEN must be >= 1");
   end

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_phase;
   logic [CNT_W-1:0] w_next_phase;
   logic [CNT_W-1:0] r_pre;
   logic [CNT_W-1:0] w_pre_next;
   logic [CNT_W-1:0] w_close_last;
   logic             r_tick;
   logic             r_closed;
   logic             r_open;
   logic             r_busy;
   logic             w_hold;
   logic             w_reopen_req;

   assign w_hold     = weight_limit_exceeded | obstruction | open_req;
   assign w_pre_next = (r_pre == TICK_LAST) ? '0 : r_pre + 1'b1;

`ifdef DOOR_NUDGE_EN
   localparam logic [CNT_W-1:0] REOPEN_MAX  = CNT_W'(MAX_REOPEN);
   localparam logic [CNT_W-1:0] NUDGE_LAST  = CNT_W'(2 * CLOSE_TIME - 1);

   logic [CNT_W-1:0] r_reopen;
   logic             r_nudge;
   logic             w_nudge_mode;

   // reopen_cnt only moves when leaving CLOSED or CLOSING, so it is stable for a whole close
   assign w_nudge_mode = (r_reopen == REOPEN_MAX);
   assign w_reopen_req = w_nudge_mode ? weight_limit_exceeded : w_hold;
   assign w_close_last = w_nudge_mode ? NUDGE_LAST : CLOSE_LAST;
   assign nudge        = r_nudge;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_reopen <= '0;
         r_nudge  <= 1'b0;
      end else begin
         if (r_state == ST_CLOSED && open_req)
            r_reopen <= '0;
         else if (r_state == ST_CLOSING && w_reopen_req && r_reopen != REOPEN_MAX)
            r_reopen <= r_reopen + 1'b1;
         r_nudge <= (w_next_state == ST_CLOSING) && w_nudge_mode;
      end
   end
`else
   assign w_reopen_req = w_hold;
   assign w_close_last = CLOSE_LAST;
   assign nudge        = 1'b0;
`endif

   always_comb begin
      w_next_state = r_state;
      w_next_phase = r_phase;
      case (r_state)
         ST_CLOSED: begin
            if (open_req) begin
               w_next_state = ST_OPENING;
               w_next_phase = '0;
            end
         end
         ST_OPENING: begin
            if (r_tick) begin
               if (r_phase == OPEN_LAST) begin
                  w_next_state = ST_OPEN;
                  w_next_phase = '0;
               end else begin
                  w_next_phase = r_phase + 1'b1;
               end
            end
         end
         ST_OPEN: begin
            // hold restarts the dwell and outranks both early close and expiry
            if (w_hold) begin
               w_next_phase = '0;
            end else if (close_req) begin
               w_next_state = ST_CLOSING;
               w_next_phase = '0;
            end else if (r_tick) begin
               if (r_phase == DWELL_LAST) begin
                  w_next_state = ST_CLOSING;
                  w_next_phase = '0;
               end else begin
                  w_next_phase = r_phase + 1'b1;
               end
            end
         end
         ST_CLOSING: begin
            if (w_reopen_req) begin
               w_next_state = ST_OPENING;
               w_next_phase = '0;
            end else if (r_tick) begin
               if (r_phase == w_close_last) begin
                  w_next_state = ST_CLOSED;
                  w_next_phase = '0;
               end else begin
                  w_next_phase = r_phase + 1'b1;
               end
            end
         end
         default: begin
            w_next_state = ST_CLOSED;
            w_next_phase = '0;
         end
      endcase
   end

   // status flags are decoded from the next state so they line up with door_state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_CLOSED;
         r_phase  <= '0;
         r_pre    <= '0;
         r_tick   <= 1'b0;
         r_closed <= 1'b1;
         r_open   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_phase  <= w_next_phase;
         r_pre    <= w_pre_next;
         r_tick   <= (w_pre_next == TICK_LAST);
         r_closed <= (w_next_state == ST_CLOSED);
         r_open   <= (w_next_state == ST_OPEN);
         r_busy   <= (w_next_state != ST_CLOSED);
      end
   end

   assign door_state      = r_state;
   assign door_closed     = r_closed;
   assign door_fully_open = r_open;
   assign door_busy       = r_busy;
   assign door_tick       = r_tick;

endmodule
